// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and counter-width helpers
// used by both the receiver and the transmitter side of the test harness.
package uart_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  // Width of a counter that must hold the values 0 .. n-1 (never below 1 bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops reset to RESET_VAL so an idle-high line never looks active after reset.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start + DATA_BITS (LSB first) + STOP_BITS, no parity, valid/ready output.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around each sample (adds one cycle of latency).
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int BW = cnt_width(DATA_BITS + STOP_BITS);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  logic rxs;
  logic bit_val;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (in),
    .sync_o  (rxs)
  );

`ifdef UART_RX_MAJORITY_EN
  // The vote is taken one cycle after the nominal instant, once the +1 sample exists.
  localparam logic [CW-1:0] START_LAST = CW'(CLKS_PER_BIT / 2);

  logic rxs_h1_q;
  logic rxs_h2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxs_h1_q <= 1'b1;
      rxs_h2_q <= 1'b1;
    end else begin
      rxs_h1_q <= rxs;
      rxs_h2_q <= rxs_h1_q;
    end
  end

  assign bit_val = (rxs & rxs_h1_q) | (rxs & rxs_h2_q) | (rxs_h1_q & rxs_h2_q);
`else
  localparam logic [CW-1:0] START_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  assign bit_val = rxs;
`endif

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      done_q      <= 1'b0;
      ferr_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      done_q      <= done_d;
      ferr_q      <= ferr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      WAIT_IDLE: begin
        if (!rxs) begin
          cnt_d = '0;
        end else if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (cnt_q == START_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = bit_val ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d                 = '0;
          shreg_d               = shreg_q >> 1;
          shreg_d[DATA_BITS-1]  = bit_val;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          // A low stop bit also covers break: wait for a full idle bit before re-arming.
          if (!bit_val) begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end else if (bit_q == STOP_LAST) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    frame_err_d = ferr_q;
    overrun_d   = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    // A consume in the same cycle frees the slot for the incoming word.
    if (done_q) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = shreg_q;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frame scenarios with randomized payloads and gaps,
// checked against expected word/arrival-time queues derived from the frame timing rules.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int SB  = 1;
  localparam int H   = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          line      = 1'b1;
  logic          out_ready = 1'b1;
  logic [DB-1:0] out_data;
  logic          out_valid;
  logic          frame_err;
  logic          overrun;

  uart_rx #(
    .DATA_BITS    (DB),
    .STOP_BITS    (SB),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (line),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log every word arrival (rising out_valid) and count flag pulses.
  logic [DB-1:0] got_data[$];
  int            got_rise[$];
  int            vld_hi_cnt = 0;
  int            fe_cnt     = 0;
  int            ov_cnt     = 0;
  int            unstable   = 0;
  logic          prev_vld   = 1'b0;
  logic [DB-1:0] prev_data  = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_vld) begin
        got_data.push_back(out_data);
        got_rise.push_back(cyc);
      end
      if (out_valid) vld_hi_cnt = vld_hi_cnt + 1;
      if (out_valid && prev_vld && out_data !== prev_data) unstable = unstable + 1;
      if (frame_err) fe_cnt = fe_cnt + 1;
      if (overrun) ov_cnt = ov_cnt + 1;
    end
    prev_vld  = out_valid;
    prev_data = out_data;
  end

  logic [DB-1:0] exp_data[$];
  int            exp_rise[$];
  int            gi = 0;
  int            ei = 0;
  int            npass = 0;
  int            nfail = 0;
  int            ntotal = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    ntotal = ntotal + 1;
    assert (obs === exp_v) npass = npass + 1;
    else begin
      nfail = nfail + 1;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
    end
  endtask

  // Drive one frame starting at the current negedge. A start edge driven at the
  // negedge after edge n is first seen by the receiver at edge n+3 (two sync flops).
  // spike_k/spike at mid-bit: one-cycle low pulse on frame bit spike_k at its sample instant.
  task automatic send_frame(input logic [DB-1:0] d, input bit stop_hi, input int spike_k,
                            input bit deliver, input logic [DB-1:0] exp_d);
    int   n0;
    logic b;
    n0 = cyc;
    if (deliver) begin
      exp_data.push_back(exp_d);
      exp_rise.push_back(n0 + 3 + H + (DB + SB) * CPB + 1 + MAJ);
    end
    for (int k = 0; k <= DB + SB; k++) begin
      if (k == 0) b = 1'b0;
      else if (k <= DB) b = d[k-1];
      else b = stop_hi;
      for (int c = 0; c < CPB; c++) begin
        line = (k == spike_k && c == H) ? 1'b0 : b;
        @(negedge clk);
      end
    end
  endtask

  task automatic idle(input int n);
    line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_words(input string tag);
    chk({tag, "_count"}, got_data.size() - gi, exp_data.size() - ei);
    while (ei < exp_data.size() && gi < got_data.size()) begin
      chk({tag, "_data"}, int'(got_data[gi]), int'(exp_data[ei]));
      chk({tag, "_rise"}, got_rise[gi], exp_rise[ei]);
      gi = gi + 1;
      ei = ei + 1;
    end
    gi = got_data.size();
    ei = exp_data.size();
  endtask

  initial begin
    int            fe0, ov0, vh0, n;
    logic [DB-1:0] w;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    idle(20);

    // Single frame
    fe0 = fe_cnt; ov0 = ov_cnt; vh0 = vld_hi_cnt;
    send_frame(8'hA5, 1'b1, -1, 1'b1, 8'hA5);
    idle(4);
    check_words("single");
    chk("single_vld_width", vld_hi_cnt - vh0, 1);
    chk("single_fe", fe_cnt - fe0, 0);
    chk("single_ov", ov_cnt - ov0, 0);

    // Back-to-back, no idle gap
    vh0 = vld_hi_cnt;
    send_frame(8'h00, 1'b1, -1, 1'b1, 8'h00);
    send_frame(8'hFF, 1'b1, -1, 1'b1, 8'hFF);
    send_frame(8'h55, 1'b1, -1, 1'b1, 8'h55);
    idle(4);
    check_words("b2b");
    chk("b2b_vld_width", vld_hi_cnt - vh0, 3);

    // Random payloads with random idle gaps
    for (int i = 0; i < 6; i++) begin
      w = DB'($urandom);
      send_frame(w, 1'b1, -1, 1'b1, w);
      idle($urandom_range(0, 20));
    end
    idle(4);
    check_words("rand");
    chk("rand_fe", fe_cnt - fe0, 0);
    chk("rand_ov", ov_cnt - ov0, 0);

    // Glitch on idle line
    line = 1'b0;
    repeat (3) @(negedge clk);
    idle(40);
    check_words("glitch");
    chk("glitch_fe", fe_cnt - fe0, 0);
    send_frame(8'h3C, 1'b1, -1, 1'b1, 8'h3C);
    idle(4);
    check_words("after_glitch");

    // Framing error followed by break, then recovery
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h81, 1'b0, -1, 1'b0, 8'h00);
    line = 1'b0;
    repeat (40) @(negedge clk);
    idle(16);
    send_frame(8'h7E, 1'b1, -1, 1'b1, 8'h7E);
    idle(4);
    check_words("ferr");
    chk("ferr_fe", fe_cnt - fe0, 1);
    chk("ferr_ov", ov_cnt - ov0, 0);

    // Overrun: second word dropped while the first is held
    fe0 = fe_cnt; ov0 = ov_cnt;
    out_ready = 1'b0;
    send_frame(8'h11, 1'b1, -1, 1'b1, 8'h11);
    send_frame(8'h22, 1'b1, -1, 1'b0, 8'h00);
    idle(10);
    check_words("ovr");
    chk("ovr_ov", ov_cnt - ov0, 1);
    chk("ovr_data_held", int'(out_data), 'h11);
    chk("ovr_vld_held", int'(out_valid), 1);
    chk("ovr_stable", unstable, 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("ovr_consumed", int'(out_valid), 0);
    chk("ovr_fe", fe_cnt - fe0, 0);

    // One-cycle low spike at the mid-bit of data bit 3 (frame bit 4)
    send_frame(8'hFF, 1'b1, 4, 1'b1, (MAJ != 0) ? 8'hFF : 8'hF7);
    idle(4);
    check_words("spike");

    // Reset in the middle of a data bit, with a word still pending
    out_ready = 1'b0;
    n = $urandom_range(1, 254);
    w = DB'(n);
    send_frame(w, 1'b1, -1, 1'b1, w);
    idle(4);
    check_words("pre_rst");
    line = 1'b0;
    repeat (CPB + H) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_data", int'(out_data), 0);
    chk("midrst_frame_err", int'(frame_err), 0);
    chk("midrst_overrun", int'(overrun), 0);
    line = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(16);
    send_frame(8'hC3, 1'b1, -1, 1'b1, 8'hC3);
    idle(4);
    check_words("post_rst");
    chk("final_stable", unstable, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver: recovers asynchronous frames of one start bit, DATA_BITS data bits (LSB first), STOP_BITS stop bits and no parity from a single input line, then presents each word on a valid/ready output. It is the receive-side counterpart of the test-harness UART transmitter and uses the same parameter set, so matching parameters yield a working link. It sits at the harness's serial input, feeding received bytes to the command/data path.

## Interface
- DATA_BITS, 8, data bits per frame
- STOP_BITS, 1, stop bits per frame; each one is checked
- CLKS_PER_BIT, 1000, clocks per bit; minimum 2, or 4 with the majority-vote option
- clk  in  1  single clock; all logic is on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in  in  1  serial line; asynchronous to clk; idle high
- out_data  out  DATA_BITS  received word; bit 0 is the first bit received
- out_valid  out  1  out_data holds an unconsumed word
- out_ready  in  1  consumer accepts the word
- frame_err  out  1  one-cycle pulse; a stop bit was sampled low
- overrun  out  1  one-cycle pulse; a word was dropped because out_valid was still high

## Operation
- `in` passes through a 2-flop synchronizer. Both flops reset to 1. The synchronized output is called rxs.
- States:
  - WAIT_IDLE: reset state. Go to IDLE after CLKS_PER_BIT consecutive cycles with rxs=1. Any 0 restarts the count.
  - IDLE: rxs=0 goes to START and clears the bit-timing counter.
  - START: at mid-bit, if rxs is still 0, go to DATA. Otherwise treat it as a glitch and return to IDLE with no flags.
  - DATA: sample one bit per bit period into a shift register. After bit DATA_BITS-1, go to STOP.
  - STOP: sample each stop bit.
    - All stop bits high: the word completes and the state goes to IDLE immediately at the last stop-bit sample, so back-to-back frames are accepted.
    - Any stop bit low: pulse frame_err, discard the word, go to WAIT_IDLE. This also handles break conditions.
- Output handshake:
  - A completed word with out_valid=0 loads out_data and sets out_valid.
  - out_valid && out_ready clears out_valid on the next edge.
  - A completed word with out_valid=1 and out_ready=0 pulses overrun and is dropped; out_data is unchanged.
  - If out_ready=1 in that same cycle, the old word is consumed and the new word loads with no overrun.
- out_data changes only on a load. It is stable while out_valid=1.

## Timing
- t0 is the edge at which rxs is first seen 0 in IDLE. H = CLKS_PER_BIT/2, using integer division.
- Sample instants:
  - Start bit: t0+H
  - Data bit i: t0+H+(i+1)·CLKS_PER_BIT
  - Stop bit j: t0+H+(DATA_BITS+1+j)·CLKS_PER_BIT
- Latency:
  - Pin-to-rxs latency is 2 cycles.
  - out_valid rises 1 cycle after the last stop-bit sample.
  - frame_err and overrun are registered and pulse in that same cycle.
- Reset values:
  - out_data=0, out_valid=0, frame_err=0, overrun=0
  - State WAIT_IDLE; counters 0
- Reset mid-frame discards the partial word. After rst_n deasserts, the line must be idle for a full bit time before a start bit is accepted.
- Tolerance: sampling at mid-bit tolerates about ±4% baud mismatch over a 10-bit frame.

## Configuration
- Macro UART_RX_MAJORITY_EN:
  - Defined:
    - Each bit, including start and stop, is a 2-of-3 majority vote of rxs at the nominal instant −1, 0 and +1.
    - The decision registers at nominal+1, so every sample instant, out_valid and the flags shift by +1 cycle.
    - Requires CLKS_PER_BIT ≥ 4.
  - Undefined: a single rxs sample at the nominal instant.

## Structure
- Shared package uart_pkg:
  - State enum: WAIT_IDLE, IDLE, START, DATA, STOP.
  - Shared counter-width helpers, which uart_tx may reuse.
- Sub-module uart_rx_sync: 2-flop synchronizer with reset value parameter RESET_VAL=1. It is reusable for other asynchronous inputs.
- Counter widths are $clog2 of CLKS_PER_BIT and of DATA_BITS+STOP_BITS.

## Test plan
Benches use CLKS_PER_BIT=16 and DATA_BITS=8 unless noted.
- Single frame:
  - Stimulus: send 0xA5 with STOP_BITS=1, out_ready held high.
  - Response: out_data=0xA5 and out_valid high for 1 cycle, rising at t0+8+9·16+1. No flags.
- Back-to-back:
  - Stimulus: send 0x00, 0xFF and 0x55 with no idle gap between frames.
  - Response: all three words arrive in order.
- Glitch:
  - Stimulus: drive a 3-cycle low pulse on an idle line.
  - Response: no out_valid and no flags. The next frame, 0x3C, is received correctly.
- Framing error and break:
  - Stimulus: send 0x81 with the stop bit driven low, then hold the line low for 40 cycles, then high for 16 cycles, then send 0x7E.
  - Response: frame_err pulses once and 0x81 is not delivered; 0x7E is then received.
- Overrun:
  - Stimulus: hold out_ready=0 and send 0x11 then 0x22.
  - Response: overrun pulses once. out_data stays 0x11 until out_ready is raised.
- Reset:
  - Stimulus: assert rst_n=0 mid-data-bit of a frame.
  - Response: all outputs are 0 immediately. After release, the next frame, 0xC3, is received correctly once the line has been idle for at least 16 cycles.
- Repeat the full suite with UART_RX_MAJORITY_EN defined. Expect every timing point +1 cycle, and a 1-cycle low spike at mid-bit must not corrupt the data.
